// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB-slave UART transmitter with a 1-deep holding buffer.
// Frames each byte as start bit, data LSB-first, optional parity, stop bit.
// Optional feature macro: UART_TX_PARITY_EN (adds parity register at addr 5
// and a PARITY state between DATA and STOP).
// Bus handshake: APB has no ready; an access commits on the edge where
// psel & penable are high, prdata/pslverr are valid combinationally while psel=1.
module apb_uart_tx #(
   parameter int BIT_PERIOD_W = 14,
   parameter int ADDR_W       = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [7:0]        pwdata,
   output logic [7:0]        prdata,
   output logic              pslverr,
   output logic              serial_out,
   output logic              tx_busy
);

   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_ERROR  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_PER_LO = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_PER_HI = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_SIZE   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_PARITY = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(6);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_TX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   // software-visible registers
   logic [BIT_PERIOD_W-1:0] bit_period_q, bit_period_d;
   logic [3:0]              data_size_q, data_size_d;
   logic [7:0]              buf_q, buf_d;
   logic                    buf_full_q, buf_full_d;
   logic                    overrun_q, overrun_d;
   logic [1:0]              par_ctrl_q, par_ctrl_d;

   // shift engine state
   state_t                  state_q;
   logic [BIT_PERIOD_W-1:0] cnt_q, per_q;
   logic [7:0]              shift_q;
   logic [3:0]              bits_q;
   logic                    par_en_q, par_bit_q, serial_out_q;

   logic       wr_en, rd_en, wr_buf, accept, drain, period_ok;
   logic [3:0] eff_size;
   logic [7:0] data_mask;
   logic       load_par_en, load_par_bit;

   assign wr_en     = psel & penable & pwrite;
   assign rd_en     = psel & penable & ~pwrite;
   assign period_ok = (bit_period_q >= BIT_PERIOD_W'(2));
   // buffer drains from IDLE or at the last clock of STOP (back-to-back frames)
   assign drain     = buf_full_q & period_ok &
                      ((state_q == S_IDLE) | ((state_q == S_STOP) & (cnt_q == '0)));
   assign wr_buf    = wr_en & (paddr == A_DATA);
   // a write while full is only accepted when the old byte leaves on the same edge
   assign accept    = wr_buf & (~buf_full_q | drain);
   assign eff_size  = ((data_size_q >= 4'd5) && (data_size_q <= 4'd8)) ? data_size_q : 4'd8;
   assign data_mask = 8'hFF >> (4'd8 - eff_size);

`ifdef UART_TX_PARITY_EN
   assign load_par_en  = par_ctrl_q[0];
   assign load_par_bit = (^(buf_q & data_mask)) ^ par_ctrl_q[1];
`else
   assign load_par_en  = 1'b0;
   assign load_par_bit = 1'b0;
`endif

   // next-state of the register file from APB writes, error-register reads and drains
   always_comb begin
      bit_period_d = bit_period_q;
      data_size_d  = data_size_q;
      buf_d        = buf_q;
      buf_full_d   = buf_full_q;
      overrun_d    = overrun_q;
      par_ctrl_d   = par_ctrl_q;
      if (wr_en) begin
         case (paddr)
            A_PER_LO: bit_period_d[7:0] = pwdata;
            A_PER_HI: bit_period_d[BIT_PERIOD_W-1:8] = pwdata[BIT_PERIOD_W-9:0];
            A_SIZE:   data_size_d = pwdata[3:0];
`ifdef UART_TX_PARITY_EN
            A_PARITY: par_ctrl_d = pwdata[1:0];
`endif
            default:  ;
         endcase
      end
      if (accept) begin
         buf_d      = pwdata;
         buf_full_d = 1'b1;
      end else if (drain) begin
         buf_full_d = 1'b0;
      end
      if (wr_buf & ~accept)
         overrun_d = 1'b1;
      else if (rd_en & (paddr == A_ERROR))
         overrun_d = 1'b0;
   end

   // register file flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_period_q <= '0;
         data_size_q  <= '0;
         buf_q        <= '0;
         buf_full_q   <= 1'b0;
         overrun_q    <= 1'b0;
         par_ctrl_q   <= '0;
      end else begin
         bit_period_q <= bit_period_d;
         data_size_q  <= data_size_d;
         buf_q        <= buf_d;
         buf_full_q   <= buf_full_d;
         overrun_q    <= overrun_d;
         par_ctrl_q   <= par_ctrl_d;
      end
   end

   // frame engine: each state holds the line for per_q clocks, config latched at load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         per_q        <= '0;
         shift_q      <= '0;
         bits_q       <= '0;
         par_en_q     <= 1'b0;
         par_bit_q    <= 1'b0;
         serial_out_q <= 1'b1;
      end else if (drain) begin
         state_q      <= S_START;
         shift_q      <= buf_q;
         per_q        <= bit_period_q;
         cnt_q        <= bit_period_q - 1'b1;
         bits_q       <= eff_size;
         par_en_q     <= load_par_en;
         par_bit_q    <= load_par_bit;
         serial_out_q <= 1'b0;
      end else if (state_q != S_IDLE) begin
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end else begin
            cnt_q <= per_q - 1'b1;
            case (state_q)
               S_START, S_DATA: begin
                  if (bits_q != 4'd0) begin
                     state_q      <= S_DATA;
                     serial_out_q <= shift_q[0];
                     shift_q      <= shift_q >> 1;
                     bits_q       <= bits_q - 4'd1;
`ifdef UART_TX_PARITY_EN
                  end else if (par_en_q) begin
                     state_q      <= S_PARITY;
                     serial_out_q <= par_bit_q;
`endif
                  end else begin
                     state_q      <= S_STOP;
                     serial_out_q <= 1'b1;
                  end
               end
`ifdef UART_TX_PARITY_EN
               S_PARITY: begin
                  state_q      <= S_STOP;
                  serial_out_q <= 1'b1;
               end
`endif
               default: begin
                  state_q      <= S_IDLE;
                  serial_out_q <= 1'b1;
               end
            endcase
         end
      end
   end

   // combinational read mux and error decode
   always_comb begin
      prdata  = 8'h00;
      pslverr = 1'b0;
      if (psel) begin
         case (paddr)
            A_STATUS: begin
               prdata  = {6'b0, buf_full_q, tx_busy};
               pslverr = pwrite;
            end
            A_ERROR: begin
               prdata  = {7'b0, overrun_q};
               pslverr = pwrite;
            end
            A_PER_LO: prdata = bit_period_q[7:0];
            A_PER_HI: prdata = 8'(bit_period_q[BIT_PERIOD_W-1:8]);
            A_SIZE:   prdata = {4'b0, data_size_q};
`ifdef UART_TX_PARITY_EN
            A_PARITY: prdata = {6'b0, par_ctrl_q};
`endif
            A_DATA:   prdata = buf_q;
            default:  pslverr = 1'b1;
         endcase
      end
   end

   assign serial_out = serial_out_q;
   assign tx_busy    = (state_q != S_IDLE);

   logic unused_par;
   assign unused_par = &{1'b0, par_en_q, par_bit_q, load_par_en, load_par_bit, par_ctrl_q};

endmodule

// File: tb/tb_apb_uart_tx.sv
// tb_apb_uart_tx: directed plus randomized checks of apb_uart_tx.
// Expected line activity comes from a frame model: each frame is a list of
// line levels (start 0, data LSB-first, optional parity, stop 1), each held
// for the bit period, with frames concatenated when queued back-to-back.
module tb_apb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel, penable, pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pslverr, serial_out, tx_busy;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  apb_uart_tx dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr),
    .serial_out(serial_out), .tx_busy(tx_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic apb_write(input logic [2:0] a, input logic [7:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic exp_err);
    logic e;
    apb_write(a, d, e);
    chk($sformatf("wr_err_a%0d", a), {7'b0, e}, {7'b0, exp_err});
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp_d, input logic exp_err);
    logic [7:0] d;
    logic e;
    apb_read(a, d, e);
    chk($sformatf("rd_data_a%0d", a), d, exp_d);
    chk($sformatf("rd_err_a%0d", a), {7'b0, e}, {7'b0, exp_err});
  endtask

  // reference model: append one frame's line levels to the expected queue
  task automatic add_frame(input logic [7:0] d, input int size_reg, input int per,
                           input logic par_en, input logic odd);
    int n;
    logic lvls[$];
    logic p;
    n = (size_reg >= 5 && size_reg <= 8) ? size_reg : 8;
    p = odd;
    lvls.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      lvls.push_back(d[i]);
      p = p ^ d[i];
    end
    if (par_en) lvls.push_back(p);
    lvls.push_back(1'b1);
    foreach (lvls[i])
      for (int c = 0; c < per; c++) exp_q.push_back(lvls[i]);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endtask

  // scoreboard: call right after the commit edge of the triggering write
  task automatic check_line(input string tag);
    logic e;
    @(posedge clk);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk(tag, {7'b0, serial_out}, {7'b0, e});
    end
  endtask

  initial begin
    int per, per2, size, size2;
    logic [7:0] d, d2;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", {7'b0, serial_out}, 8'h01);
    chk("rst_busy", {7'b0, tx_busy}, 8'h00);
    rst = 1'b0;

    // reset values
    rd(3'd0, 8'h00, 1'b0);
    rd(3'd1, 8'h00, 1'b0);
    rd(3'd2, 8'h00, 1'b0);
    rd(3'd3, 8'h00, 1'b0);
    rd(3'd4, 8'h00, 1'b0);
    rd(3'd6, 8'h00, 1'b0);

    // configuration read-back
    wr(3'd2, 8'h0A, 1'b0);
    wr(3'd3, 8'h00, 1'b0);
    wr(3'd4, 8'h08, 1'b0);
    rd(3'd2, 8'h0A, 1'b0);
    rd(3'd3, 8'h00, 1'b0);
    rd(3'd4, 8'h08, 1'b0);

    // single frame 8'h66
    add_frame(8'h66, 8, 10, 1'b0, 1'b0);
    add_idle(5);
    wr(3'd6, 8'h66, 1'b0);
    check_line("line_66");
    rd(3'd0, 8'h00, 1'b0);

    // back-to-back frames and overrun
    add_frame(8'hA5, 8, 10, 1'b0, 1'b0);
    add_frame(8'h5A, 8, 10, 1'b0, 1'b0);
    add_idle(3);
    wr(3'd6, 8'hA5, 1'b0);
    fork
      check_line("line_b2b");
      begin
        wr(3'd6, 8'h5A, 1'b0);
        wr(3'd6, 8'h33, 1'b0);
        rd(3'd0, 8'h03, 1'b0);
        rd(3'd6, 8'h5A, 1'b0);
        rd(3'd1, 8'h01, 1'b0);
        rd(3'd1, 8'h00, 1'b0);
      end
    join
    rd(3'd0, 8'h00, 1'b0);

    // illegal accesses leave registers unchanged
    wr(3'd0, 8'hFF, 1'b1);
    wr(3'd1, 8'hFF, 1'b1);
    wr(3'd7, 8'hFF, 1'b1);
    rd(3'd7, 8'h00, 1'b1);
`ifndef UART_TX_PARITY_EN
    wr(3'd5, 8'hFF, 1'b1);
    rd(3'd5, 8'h00, 1'b1);
`endif
    rd(3'd0, 8'h00, 1'b0);
    rd(3'd1, 8'h00, 1'b0);
    rd(3'd2, 8'h0A, 1'b0);
    rd(3'd4, 8'h08, 1'b0);

`ifdef UART_TX_PARITY_EN
    wr(3'd5, 8'h01, 1'b0);
    rd(3'd5, 8'h01, 1'b0);
    add_frame(8'h07, 8, 10, 1'b1, 1'b0);
    add_idle(2);
    wr(3'd6, 8'h07, 1'b0);
    check_line("line_par_even");
    wr(3'd5, 8'h03, 1'b0);
    add_frame(8'h07, 8, 10, 1'b1, 1'b1);
    add_idle(2);
    wr(3'd6, 8'h07, 1'b0);
    check_line("line_par_odd");
    wr(3'd5, 8'h00, 1'b0);
`endif

    // bit period below 2 holds the byte in the buffer
    wr(3'd2, 8'h01, 1'b0);
    wr(3'd6, 8'hC3, 1'b0);
    add_idle(20);
    check_line("line_hold");
    rd(3'd0, 8'h02, 1'b0);
    add_frame(8'hC3, 8, 3, 1'b0, 1'b0);
    add_idle(2);
    wr(3'd2, 8'h03, 1'b0);
    check_line("line_release");

    // randomized frames, odd iterations queue a second byte with new config mid-frame
    for (int it = 0; it < 10; it++) begin
      per  = $urandom_range(2, 12);
      size = $urandom_range(0, 15);
      d    = 8'($urandom_range(0, 255));
      wr(3'd2, 8'(per), 1'b0);
      wr(3'd4, 8'(size), 1'b0);
      add_frame(d, size, per, 1'b0, 1'b0);
      if (it % 2 == 1) begin
        per2  = $urandom_range(2, 12);
        size2 = $urandom_range(0, 15);
        d2    = 8'($urandom_range(0, 255));
        add_frame(d2, size2, per2, 1'b0, 1'b0);
        add_idle(2);
        wr(3'd6, d, 1'b0);
        fork
          check_line("line_rand2");
          begin
            wr(3'd2, 8'(per2), 1'b0);
            wr(3'd4, 8'(size2), 1'b0);
            wr(3'd6, d2, 1'b0);
          end
        join
      end else begin
        add_idle(2);
        wr(3'd6, d, 1'b0);
        check_line("line_rand1");
      end
      rd(3'd0, 8'h00, 1'b0);
    end

    // asynchronous reset aborts a frame mid-bit
    wr(3'd6, 8'h00, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", {7'b0, tx_busy}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("abort_line", {7'b0, serial_out}, 8'h01);
    chk("abort_busy", {7'b0, tx_busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd2, 8'h00, 1'b0);
    rd(3'd0, 8'h00, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
